// File: rtl/cache_refill_ctrl.sv
// Miss-side controller for a direct-mapped data cache: owns the tag/valid/dirty arrays,
// writes back dirty victims, fetches the missing block and refills the data array.
module cache_refill_ctrl #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 3,
  parameter int BLOCK_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [INDEX_W-1:0]       lookup_index,
  output logic [TAG_W-1:0]         lookup_tag,
  output logic                     lookup_valid,
  output logic                     lookup_dirty,
  input  logic                     set_dirty,
  input  logic [INDEX_W-1:0]       set_dirty_idx,
  input  logic                     miss_req,
  input  logic [INDEX_W-1:0]       miss_index,
  input  logic [TAG_W-1:0]         miss_tag,
  input  logic [BLOCK_W-1:0]       victim_data,
  output logic                     busywait,
  output logic                     fill_we,
  output logic [INDEX_W-1:0]       fill_index,
  output logic [BLOCK_W-1:0]       fill_data,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+INDEX_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]       mem_writedata,
  input  logic [BLOCK_W-1:0]       mem_readdata,
  input  logic                     mem_busywait
);

  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t               state_q, state_d;
  logic [INDEX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [TAG_W-1:0]     victim_tag_q, victim_tag_d;
  logic [BLOCK_W-1:0]   victim_data_q, victim_data_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic                 seen_busy_q, seen_busy_d;
  logic [TAG_W-1:0]     tag_q [LINES];
  logic [TAG_W-1:0]     tag_d [LINES];
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic                 mem_done;

  assign lookup_tag   = tag_q[lookup_index];
  assign lookup_valid = valid_q[lookup_index];
  assign lookup_dirty = dirty_q[lookup_index];

  // A transfer only completes once memory has shown busy at least once, so a
  // memory that raises busywait a cycle late cannot cause a premature exit.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    miss_tag_d    = miss_tag_q;
    victim_tag_d  = victim_tag_q;
    victim_data_d = victim_data_q;
    block_d       = block_q;
    seen_busy_d   = seen_busy_q;
    busywait      = 1'b0;
    fill_we       = 1'b0;
    fill_index    = '0;
    fill_data     = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    mem_done      = !mem_busywait && seen_busy_q;

    case (state_q)
      IDLE: begin
        busywait = miss_req;
        if (miss_req) begin
          idx_d      = miss_index;
          miss_tag_d = miss_tag;
          if (valid_q[miss_index] && dirty_q[miss_index]) begin
            victim_tag_d  = tag_q[miss_index];
            victim_data_d = victim_data;
            state_d       = WRITEBACK;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {victim_tag_q, idx_q};
        mem_writedata = victim_data_q;
        if (mem_done) begin
          state_d     = FETCH;
          seen_busy_d = 1'b0;
        end else if (mem_busywait) begin
          seen_busy_d = 1'b1;
        end
      end
      FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {miss_tag_q, idx_q};
        if (mem_done) begin
          state_d     = UPDATE;
          seen_busy_d = 1'b0;
          block_d     = mem_readdata;
        end else if (mem_busywait) begin
          seen_busy_d = 1'b1;
        end
      end
      UPDATE: begin
        busywait   = 1'b1;
        fill_we    = 1'b1;
        fill_index = idx_q;
        fill_data  = block_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A miss to the same line in the same cycle takes priority over set_dirty.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (state_q == UPDATE) begin
      tag_d[idx_q]   = miss_tag_q;
      valid_d[idx_q] = 1'b1;
      dirty_d[idx_q] = 1'b0;
    end else if (state_q == IDLE && set_dirty && valid_q[set_dirty_idx] &&
                 !(miss_req && miss_index == set_dirty_idx)) begin
      dirty_d[set_dirty_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      miss_tag_q    <= '0;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      block_q       <= '0;
      seen_busy_q   <= 1'b0;
      valid_q       <= '0;
      dirty_q       <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      miss_tag_q    <= miss_tag_d;
      victim_tag_q  <= victim_tag_d;
      victim_data_q <= victim_data_d;
      block_q       <= block_d;
      seen_busy_q   <= seen_busy_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: clean miss, dirty writeback, late memory busy,
// reset mid-transfer and ignored requests, checked with immediate assertions.
module tb_cache_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  lookup_index;
  logic [2:0]  lookup_tag;
  logic        lookup_valid;
  logic        lookup_dirty;
  logic        set_dirty;
  logic [2:0]  set_dirty_idx;
  logic        miss_req;
  logic [2:0]  miss_index;
  logic [2:0]  miss_tag;
  logic [31:0] victim_data;
  logic        busywait;
  logic        fill_we;
  logic [2:0]  fill_index;
  logic [31:0] fill_data;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int total  = 0;
  int passed = 0;

  cache_refill_ctrl #(.TAG_W(3), .INDEX_W(3), .BLOCK_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .lookup_index  (lookup_index),
    .lookup_tag    (lookup_tag),
    .lookup_valid  (lookup_valid),
    .lookup_dirty  (lookup_dirty),
    .set_dirty     (set_dirty),
    .set_dirty_idx (set_dirty_idx),
    .miss_req      (miss_req),
    .miss_index    (miss_index),
    .miss_tag      (miss_tag),
    .victim_data   (victim_data),
    .busywait      (busywait),
    .fill_we       (fill_we),
    .fill_index    (fill_index),
    .fill_data     (fill_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic look(input logic [2:0] idx);
    lookup_index = idx;
    #1;
  endtask

  initial begin
    reset = 1'b0; lookup_index = '0; set_dirty = 1'b0; set_dirty_idx = '0;
    miss_req = 1'b0; miss_index = '0; miss_tag = '0; victim_data = '0;
    mem_readdata = '0; mem_busywait = 1'b0;

    // 1: reset state
    tick(); tick();
    reset = 1'b1;
    look(3'd3);
    chk("rst_valid", 32'(lookup_valid), 32'd0);
    chk("rst_dirty", 32'(lookup_dirty), 32'd0);
    chk("rst_tag",   32'(lookup_tag),   32'd0);
    chk("rst_mem_read",  32'(mem_read),  32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_busywait",  32'(busywait),  32'd0);
    chk("rst_fill_we",   32'(fill_we),   32'd0);

    // 2: clean miss idx2 tag5, memory busy 5 cycles
    miss_req = 1'b1; miss_index = 3'd2; miss_tag = 3'd5;
    #1;
    chk("idle_miss_busywait", 32'(busywait), 32'd1);
    tick();
    miss_req = 1'b0; miss_index = 3'd7; miss_tag = 3'd0;
    mem_busywait = 1'b1;
    #1;
    chk("c2_mem_read", 32'(mem_read), 32'd1);
    chk("c2_mem_write", 32'(mem_write), 32'd0);
    chk("c2_addr", 32'(mem_address), 32'(6'b101010));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c2_hold_read", 32'(mem_read), 32'd1);
    end
    mem_busywait = 1'b0; mem_readdata = 32'hCAFEF00D;
    tick();
    mem_readdata = 32'h0;
    look(3'd2);
    chk("c2_fill_we", 32'(fill_we), 32'd1);
    chk("c2_fill_index", 32'(fill_index), 32'd2);
    chk("c2_fill_data", fill_data, 32'hCAFEF00D);
    chk("c2_upd_read_low", 32'(mem_read), 32'd0);
    chk("c2_upd_busywait", 32'(busywait), 32'd1);
    chk("c2_upd_old_valid", 32'(lookup_valid), 32'd0);
    tick();
    chk("c2_valid", 32'(lookup_valid), 32'd1);
    chk("c2_tag", 32'(lookup_tag), 32'd5);
    chk("c2_dirty", 32'(lookup_dirty), 32'd0);
    chk("c2_idle_busywait", 32'(busywait), 32'd0);
    chk("c2_idle_fill_we", 32'(fill_we), 32'd0);

    // 3: dirty line writeback then fetch
    set_dirty = 1'b1; set_dirty_idx = 3'd2;
    tick();
    set_dirty = 1'b0;
    #1;
    chk("c3_dirty_set", 32'(lookup_dirty), 32'd1);
    miss_req = 1'b1; miss_index = 3'd2; miss_tag = 3'd1; victim_data = 32'hDEADBEEF;
    tick();
    miss_req = 1'b0; victim_data = 32'h0; mem_busywait = 1'b1;
    #1;
    chk("c3_mem_write", 32'(mem_write), 32'd1);
    chk("c3_wb_read_low", 32'(mem_read), 32'd0);
    chk("c3_wb_addr", 32'(mem_address), 32'(6'b101010));
    chk("c3_wb_data", mem_writedata, 32'hDEADBEEF);
    tick(); tick();
    mem_busywait = 1'b0;
    tick();
    chk("c3_f_mem_read", 32'(mem_read), 32'd1);
    chk("c3_f_write_low", 32'(mem_write), 32'd0);
    chk("c3_f_addr", 32'(mem_address), 32'(6'b001010));
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0; mem_readdata = 32'h12345678;
    tick();
    mem_readdata = 32'h0;
    #1;
    chk("c3_fill_data", fill_data, 32'h12345678);
    tick();
    chk("c3_tag", 32'(lookup_tag), 32'd1);
    chk("c3_dirty_clr", 32'(lookup_dirty), 32'd0);
    chk("c3_valid", 32'(lookup_valid), 32'd1);

    // 4: memory raises busywait one cycle late
    miss_req = 1'b1; miss_index = 3'd4; miss_tag = 3'd3;
    tick();
    miss_req = 1'b0;
    #1;
    chk("c4_mem_read", 32'(mem_read), 32'd1);
    tick();
    chk("c4_no_early_exit", 32'(mem_read), 32'd1);
    chk("c4_no_fill", 32'(fill_we), 32'd0);
    mem_busywait = 1'b1;
    tick();
    chk("c4_still_read", 32'(mem_read), 32'd1);
    mem_busywait = 1'b0;
    tick();
    chk("c4_fill_we", 32'(fill_we), 32'd1);
    chk("c4_fill_index", 32'(fill_index), 32'd4);
    tick();

    // 5: reset mid-fetch
    miss_req = 1'b1; miss_index = 3'd6; miss_tag = 3'd2;
    tick();
    miss_req = 1'b0; mem_busywait = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; mem_busywait = 1'b0;
    look(3'd6);
    chk("c5_read_low", 32'(mem_read), 32'd0);
    chk("c5_busywait_low", 32'(busywait), 32'd0);
    chk("c5_valid6", 32'(lookup_valid), 32'd0);
    look(3'd2);
    chk("c5_valid2_cleared", 32'(lookup_valid), 32'd0);
    chk("c5_tag2_cleared", 32'(lookup_tag), 32'd0);
    tick();
    chk("c5_no_fill", 32'(fill_we), 32'd0);

    // 6: set_dirty on invalid line; miss_req while in FETCH
    set_dirty = 1'b1; set_dirty_idx = 3'd1;
    tick();
    set_dirty = 1'b0;
    look(3'd1);
    chk("c6_invalid_dirty", 32'(lookup_dirty), 32'd0);
    miss_req = 1'b1; miss_index = 3'd3; miss_tag = 3'd4;
    tick();
    miss_index = 3'd0; miss_tag = 3'd7; mem_busywait = 1'b1;
    #1;
    chk("c6_addr_kept", 32'(mem_address), 32'(6'b100011));
    tick();
    chk("c6_addr_kept2", 32'(mem_address), 32'(6'b100011));
    mem_busywait = 1'b0;
    tick();
    miss_req = 1'b0;
    #1;
    chk("c6_fill_index", 32'(fill_index), 32'd3);
    tick();
    look(3'd3);
    chk("c6_tag3", 32'(lookup_tag), 32'd4);
    look(3'd0);
    chk("c6_valid0", 32'(lookup_valid), 32'd0);
    chk("c6_idle", 32'(busywait), 32'd0);

    // set_dirty and miss to the same clean line: the miss wins
    set_dirty = 1'b1; set_dirty_idx = 3'd3;
    miss_req = 1'b1; miss_index = 3'd3; miss_tag = 3'd6;
    tick();
    set_dirty = 1'b0; miss_req = 1'b0;
    look(3'd3);
    chk("mw_fetch", 32'(mem_read), 32'd1);
    chk("mw_no_wb", 32'(mem_write), 32'd0);
    chk("mw_addr", 32'(mem_address), 32'(6'b110011));
    chk("mw_dirty", 32'(lookup_dirty), 32'd0);
    mem_busywait = 1'b1;
    tick();
    mem_busywait = 1'b0;
    tick();
    tick();
    chk("mw_tag3", 32'(lookup_tag), 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
